// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU gatekeeper sequencer.
// Holds the datapath word and the sequencer state encoding.
package hs_npu_pkg;

    typedef logic [31:0] uword;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } gk_seq_state_t;

endpackage

// File: rtl/hs_npu_gk_sequencer.sv
// Job sequencer for the skewed gatekeeper chain: waits for data,
// fires the start pulse, times the run window and reports completion.
module hs_npu_gk_sequencer
    import hs_npu_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  uword                 job_cycles,
    input  logic                 abort,
    input  logic [NUM_LANES-1:0] lane_valid,
    input  logic                 out_ready,
    output logic                 gk_start,
    output uword                 gk_enable_cycles,
    output logic                 fifo_flush,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam logic [CNT_W:0] LANE_EXTRA = (CNT_W + 1)'(NUM_LANES - 1);

    gk_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    uword             cyc_q, cyc_d;
    logic             und_q, und_d;
    logic             start_q, start_d;
    logic             flush_q, flush_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             all_ok;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] run_len;

    always_comb begin
        all_ok  = (&lane_valid) && out_ready;
        // Extra carry bit lets the skew add clamp instead of wrapping.
        sum     = {1'b0, CNT_W'(cyc_q)} + LANE_EXTRA;
        run_len = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        und_d   = und_q;
        start_d = 1'b0;
        flush_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (job_valid && ready_q) begin
                    cyc_d = job_cycles;
                    und_d = 1'b0;
                    if (job_cycles == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (abort) begin
                    state_d = IDLE;
                    flush_d = 1'b1;
                end else if (all_ok) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    cnt_d   = run_len;
                end
            end
            RUN: begin
                // Gatekeepers cannot stall, so starvation is only flagged.
                if (!all_ok) begin
                    und_d = 1'b1;
                end
                if (abort) begin
                    state_d = IDLE;
                    flush_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            und_q   <= 1'b0;
            start_q <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            und_q   <= und_d;
            start_q <= start_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign job_ready        = ready_q;
    assign gk_start         = start_q;
    assign gk_enable_cycles = cyc_q;
    assign fifo_flush       = flush_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign underrun         = und_q;

endmodule

// File: tb/tb_hs_npu_gk_sequencer.sv
// Directed bench for hs_npu_gk_sequencer: table of job vectors
// plus hand-written abort and asynchronous reset sequences.
module tb_hs_npu_gk_sequencer;
    import hs_npu_pkg::*;

    localparam int NL = 4;

    logic          clk_core = 1'b0;
    logic          rst_core_n = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    uword          job_cycles = '0;
    logic          abort = 1'b0;
    logic [NL-1:0] lane_valid = '1;
    logic          out_ready = 1'b1;
    logic          gk_start;
    uword          gk_enable_cycles;
    logic          fifo_flush;
    logic          busy;
    logic          done;
    logic          underrun;

    int n_chk = 0;
    int n_bad = 0;

    hs_npu_gk_sequencer #(.NUM_LANES(NL), .CNT_W(32)) dut (
        .clk_core         (clk_core),
        .rst_core_n       (rst_core_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_cycles       (job_cycles),
        .abort            (abort),
        .lane_valid       (lane_valid),
        .out_ready        (out_ready),
        .gk_start         (gk_start),
        .gk_enable_cycles (gk_enable_cycles),
        .fifo_flush       (fifo_flush),
        .busy             (busy),
        .done             (done),
        .underrun         (underrun)
    );

    always #5 clk_core = ~clk_core;

    // k counts edges after the transfer edge (k=0 is the transfer edge).
    // wait_n: edges 1..wait_n see lane_valid=0111; drop_k: edge with lane 2 low.
    typedef struct {
        int c;
        int wait_n;
        int drop_k;
        int exp_start;
        int exp_done;
        int exp_und;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int start_k;
        int start_n;
        int done_k;
        int und_at_done;
        bit fin;
        start_k = -1;
        start_n = 0;
        done_k  = -1;
        und_at_done = -1;
        fin = 1'b0;
        chk($sformatf("v%0d ready_idle", idx), job_ready, 1);
        job_valid  = 1'b1;
        job_cycles = uword'(v.c);
        lane_valid = 4'b1111;
        tick();
        job_valid = 1'b0;
        chk($sformatf("v%0d ready_after_xfer", idx), job_ready, 0);
        chk($sformatf("v%0d und_cleared", idx), underrun, 0);
        chk($sformatf("v%0d busy", idx), busy, 1);
        for (int k = 0; k <= 100 && !fin; k++) begin
            if (k > 0) begin
                if (k <= v.wait_n) lane_valid = 4'b0111;
                else if (k == v.drop_k) lane_valid = 4'b1011;
                else lane_valid = 4'b1111;
                tick();
            end
            if (gk_start) begin
                start_n++;
                if (start_k < 0) start_k = k;
            end
            if (done) begin
                done_k = k;
                und_at_done = int'(underrun);
                chk($sformatf("v%0d enable_cycles", idx), gk_enable_cycles, v.c);
                fin = 1'b1;
            end
        end
        lane_valid = 4'b1111;
        chk($sformatf("v%0d start_k", idx), start_k, v.exp_start);
        chk($sformatf("v%0d start_n", idx), start_n, (v.c > 0) ? 1 : 0);
        chk($sformatf("v%0d done_k", idx), done_k, v.exp_done);
        chk($sformatf("v%0d und", idx), und_at_done, v.exp_und);
        tick();
        chk($sformatf("v%0d done_pulse", idx), done, 0);
        chk($sformatf("v%0d ready_back", idx), job_ready, 1);
        chk($sformatf("v%0d und_sticky", idx), underrun, v.exp_und);
    endtask

    initial begin
        // Nominal: start at edge 1, RUN 8 cycles, done at edge 9.
        vecs[0] = '{c: 5,  wait_n: 0, drop_k: -1, exp_start: 1,  exp_done: 9,  exp_und: 0};
        vecs[1] = '{c: 0,  wait_n: 0, drop_k: -1, exp_start: -1, exp_done: 0,  exp_und: 0};
        vecs[2] = '{c: 5,  wait_n: 6, drop_k: -1, exp_start: 7,  exp_done: 15, exp_und: 0};
        vecs[3] = '{c: 3,  wait_n: 0, drop_k: 3,  exp_start: 1,  exp_done: 7,  exp_und: 1};
        vecs[4] = '{c: 1,  wait_n: 2, drop_k: -1, exp_start: 3,  exp_done: 7,  exp_und: 0};
        vecs[5] = '{c: 10, wait_n: 1, drop_k: 10, exp_start: 2,  exp_done: 15, exp_und: 1};
        vecs[6] = '{c: 2,  wait_n: 0, drop_k: -1, exp_start: 1,  exp_done: 6,  exp_und: 0};

        #12;
        chk("rst busy", busy, 0);
        chk("rst ready", job_ready, 0);
        chk("rst enable", gk_enable_cycles, 0);
        chk("rst und", underrun, 0);
        #5 rst_core_n = 1'b1;
        tick();
        chk("post_rst ready", job_ready, 1);
        chk("post_rst busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort flush", fifo_flush, 0);
        chk("idle_abort ready", job_ready, 1);

        // Abort on final RUN cycle (C=2 -> counter 5, last RUN sample k=5).
        job_valid  = 1'b1;
        job_cycles = 2;
        tick();
        job_valid = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("coll busy_pre", busy, 1);
        chk("coll done_pre", done, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("coll flush", fifo_flush, 1);
        chk("coll done", done, 0);
        chk("coll busy", busy, 0);
        chk("coll ready", job_ready, 1);
        tick();
        chk("coll flush_one", fifo_flush, 0);
        chk("coll done_late", done, 0);

        // Abort while waiting for data.
        job_valid  = 1'b1;
        job_cycles = 4;
        tick();
        job_valid  = 1'b0;
        lane_valid = 4'b0011;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        lane_valid = 4'b1111;
        chk("wabort flush", fifo_flush, 1);
        chk("wabort start", gk_start, 0);
        chk("wabort ready", job_ready, 1);

        // Asynchronous reset mid-RUN, away from a clock edge.
        job_valid  = 1'b1;
        job_cycles = 5;
        tick();
        job_valid = 1'b0;
        tick();
        chk("arst start", gk_start, 1);
        tick();
        tick();
        chk("arst busy_pre", busy, 1);
        #2 rst_core_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst flush", fifo_flush, 0);
        chk("arst start0", gk_start, 0);
        chk("arst enable", gk_enable_cycles, 0);
        chk("arst und", underrun, 0);
        #4 rst_core_n = 1'b1;
        tick();
        chk("arst done_after", done, 0);
        chk("arst flush_after", fifo_flush, 0);
        run_vec(7, vecs[0]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
